// File: rtl/multi_change_detector.sv
// Multi-channel change detector: reports each per-channel value change as a held strobe (lowest pending channel first).
// Latency: sig_in -> pending 1 edge, -> change 2 edges (STABLE_CYCLES+1 / +2 with CHANGE_DEBOUNCE_EN defined).
// Backpressure: a report is held until i_ack or HOLD_CYCLES timeout; further changes queue per channel and coalesce (o_overrun).
module multi_change_detector #(
  parameter int CHANNELS      = 4,
  parameter int WIDTH         = 3,
  parameter int HOLD_CYCLES   = 20,
  parameter int STABLE_CYCLES = 4,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
  localparam int HW = $clog2(HOLD_CYCLES + 1)
) (
  input  logic                      i_clk,
  input  logic                      i_reset,        // asynchronous, active-low
  input  logic [CHANNELS*WIDTH-1:0] i_sig_in,
  input  logic                      i_ack,
  output logic                      o_change,
  output logic [CW-1:0]             o_change_ch,
  output logic [WIDTH-1:0]          o_change_prev,
  output logic [WIDTH-1:0]          o_change_value,
  output logic [CHANNELS-1:0]       o_pending,
  output logic                      o_overrun
);

  typedef enum logic {S_IDLE, S_REPORT} state_t;

  // Elaboration-time sanity checks on the configuration.
  if (CHANNELS < 1 || WIDTH < 1 || HOLD_CYCLES < 1 || STABLE_CYCLES < 1) begin : g_param_check
    $error("multi_change_detector: all parameters must be >= 1");
  end

  logic [WIDTH-1:0]    w_sig   [CHANNELS];
  logic [WIDTH-1:0]    r_last  [CHANNELS];
  logic [WIDTH-1:0]    r_prev  [CHANNELS];
  logic [CHANNELS-1:0] r_pend;
  logic [CHANNELS-1:0] w_det;
  logic [CHANNELS-1:0] w_clr;
  logic                w_any;
  logic [CW-1:0]       w_sel;
  logic                r_overrun;

  state_t              r_state;
  logic [HW-1:0]       r_hold;
  logic                r_change;
  logic [CW-1:0]       r_ch;
  logic [WIDTH-1:0]    r_out_prev;
  logic [WIDTH-1:0]    r_out_val;

  genvar g;
  for (g = 0; g < CHANNELS; g++) begin : g_split
    assign w_sig[g] = i_sig_in[g*WIDTH +: WIDTH];
  end

`ifdef CHANGE_DEBOUNCE_EN
  localparam int SW = $clog2(STABLE_CYCLES + 1);

  logic [WIDTH-1:0] r_cand [CHANNELS];
  logic [SW-1:0]    r_stab [CHANNELS];

  // Track the candidate input value and how many consecutive edges it has been seen (saturating).
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_cand[k] <= '0;
        r_stab[k] <= '0;
      end
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (w_sig[k] != r_cand[k]) begin
          r_cand[k] <= w_sig[k];
          r_stab[k] <= SW'(1);
        end else if (r_stab[k] != SW'(STABLE_CYCLES)) begin
          r_stab[k] <= r_stab[k] + SW'(1);
        end
      end
    end
  end

  // A new value is accepted only on the edge after it has been seen STABLE_CYCLES times in a row.
  always_comb begin
    w_det = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_det[k] = (w_sig[k] == r_cand[k]) && (r_stab[k] == SW'(STABLE_CYCLES)) &&
                 (w_sig[k] != r_last[k]);
    end
  end
`else
  // Any difference from the accepted value is a change.
  always_comb begin
    w_det = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      w_det[k] = (w_sig[k] != r_last[k]);
    end
  end
`endif

  // Lowest-index pending channel wins; the clear only fires when the IDLE state latches it.
  always_comb begin
    w_any = 1'b0;
    w_sel = '0;
    w_clr = '0;
    for (int k = CHANNELS - 1; k >= 0; k--) begin
      if (r_pend[k]) begin
        w_any = 1'b1;
        w_sel = CW'(k);
      end
    end
    for (int k = 0; k < CHANNELS; k++) begin
      w_clr[k] = (r_state == S_IDLE) && w_any && (w_sel == CW'(k));
    end
  end

  // Per-channel last/prev/pend bookkeeping; a new change beats the report's clear on the same edge.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      for (int k = 0; k < CHANNELS; k++) begin
        r_last[k] <= '0;
        r_prev[k] <= '0;
      end
      r_pend    <= '0;
      r_overrun <= 1'b0;
    end else begin
      for (int k = 0; k < CHANNELS; k++) begin
        if (w_det[k]) begin
          r_last[k] <= w_sig[k];
          r_pend[k] <= 1'b1;
          // Start a fresh old-value snapshot unless an unreported change is being coalesced.
          if (!r_pend[k] || w_clr[k]) begin
            r_prev[k] <= r_last[k];
          end
        end else if (w_clr[k]) begin
          r_pend[k] <= 1'b0;
        end
      end
      // Coalescing: a channel still waiting (and not being taken this edge) changed again.
      r_overrun <= |(w_det & r_pend & ~w_clr);
    end
  end

  // Report FSM: latch a pending channel in IDLE, hold the report until ack or timeout.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state    <= S_IDLE;
      r_hold     <= '0;
      r_change   <= 1'b0;
      r_ch       <= '0;
      r_out_prev <= '0;
      r_out_val  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_hold <= '0;
          if (w_any) begin
            r_ch       <= w_sel;
            r_out_prev <= r_prev[w_sel];
            r_out_val  <= r_last[w_sel];
            r_change   <= 1'b1;
            r_state    <= S_REPORT;
          end
        end
        S_REPORT: begin
          if (i_ack || (r_hold == HW'(HOLD_CYCLES - 1))) begin
            r_change <= 1'b0;
            r_hold   <= '0;
            r_state  <= S_IDLE;
          end else begin
            r_hold <= r_hold + HW'(1);
          end
        end
        default: begin
          r_change <= 1'b0;
          r_hold   <= '0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign o_change       = r_change;
  assign o_change_ch    = r_ch;
  assign o_change_prev  = r_out_prev;
  assign o_change_value = r_out_val;
  assign o_pending      = r_pend;
  assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_multi_change_detector.sv
// Scoreboard bench for multi_change_detector: directed vectors, expected reports queued by stimulus.
// A negedge monitor pops one expectation per report and checks fields, length and stability.
// Debounce vectors are used when CHANGE_DEBOUNCE_EN is defined, the default-timing vectors otherwise.
module tb_multi_change_detector;

  localparam int CH = 4;
  localparam int W  = 3;
  localparam int HOLD = 20;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [CH*W-1:0] sig_in = '0;
  logic          ack = 1'b0;
  logic          change;
  logic [1:0]    change_ch;
  logic [W-1:0]  change_prev;
  logic [W-1:0]  change_value;
  logic [CH-1:0] pending;
  logic          overrun;

  typedef struct {
    int ch;
    int prev;
    int val;
    int len;
  } rep_t;

  rep_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  multi_change_detector #(
    .CHANNELS(CH), .WIDTH(W), .HOLD_CYCLES(HOLD), .STABLE_CYCLES(4)
  ) dut (
    .i_clk(clk), .i_reset(rst_n), .i_sig_in(sig_in), .i_ack(ack),
    .o_change(change), .o_change_ch(change_ch), .o_change_prev(change_prev),
    .o_change_value(change_value), .o_pending(pending), .o_overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input int v);
    sig_in[k*W +: W] = W'(v);
  endtask

  task automatic push(input int c, input int p, input int v, input int l);
    rep_t r;
    r.ch = c; r.prev = p; r.val = v; r.len = l;
    exp_q.push_back(r);
  endtask

  // Wait (bounded) until change equals lvl; an expired budget is a failed comparison.
  task automatic wait_change(input logic lvl, input int budget, input string nm);
    int i;
    i = 0;
    while (change !== lvl && i < budget) begin
      tick();
      i++;
    end
    if (change !== lvl) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: timeout waiting for change=%0d", nm, lvl);
    end
  endtask

  // Monitor: one expectation per observed report.
  bit   in_rep = 0;
  bit   have_exp = 0;
  bit   frozen_ok = 1;
  int   cur_len = 0;
  rep_t cur_exp;
  logic [1:0]   cap_ch;
  logic [W-1:0] cap_prev, cap_val;

  always @(negedge clk) begin
    if (change && !in_rep) begin
      in_rep = 1;
      cur_len = 1;
      frozen_ok = 1;
      cap_ch = change_ch; cap_prev = change_prev; cap_val = change_value;
      if (exp_q.size() == 0) begin
        have_exp = 0;
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_report: ch=%0d prev=%0d val=%0d", change_ch, change_prev, change_value);
      end else begin
        cur_exp = exp_q.pop_front();
        have_exp = 1;
        chk("rep_ch", int'(change_ch), cur_exp.ch);
        chk("rep_prev", int'(change_prev), cur_exp.prev);
        chk("rep_value", int'(change_value), cur_exp.val);
      end
    end else if (change && in_rep) begin
      cur_len++;
      if (change_ch != cap_ch || change_prev != cap_prev || change_value != cap_val) frozen_ok = 0;
    end else if (!change && in_rep) begin
      in_rep = 0;
      if (have_exp) chk("rep_len", cur_len, cur_exp.len);
      chk("rep_frozen", int'(frozen_ok), 1);
    end
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_change", int'(change), 0);
    chk("rst_ch", int'(change_ch), 0);
    chk("rst_prev", int'(change_prev), 0);
    chk("rst_value", int'(change_value), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_overrun", int'(overrun), 0);
    rst_n = 1'b1;
    tick(); tick();
    chk("zero_no_report", int'(change), 0);

`ifdef CHANGE_DEBOUNCE_EN
    // 3-cycle glitch on ch0 is filtered
    set_ch(0, 5);
    repeat (3) tick();
    set_ch(0, 0);
    repeat (8) tick();
    chk("glitch_pending", int'(pending), 0);
    chk("glitch_change", int'(change), 0);
    // Held value is accepted after STABLE_CYCLES+1 edges
    set_ch(0, 5);
    repeat (4) tick();
    chk("db_pending_e4", int'(pending[0]), 0);
    push(0, 0, 5, 1);
    tick();
    chk("db_pending_e5", int'(pending[0]), 1);
    tick();
    chk("db_change", int'(change), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("db_ack_fall", int'(change), 0);
    repeat (8) tick();
    chk("db_no_repeat", int'(change), 0);
`else
    // Single change, no ack: full HOLD-cycle report
    set_ch(2, 5);
    tick();
    chk("t1_pending", int'(pending), 4);
    chk("t1_change_early", int'(change), 0);
    push(2, 0, 5, HOLD);
    tick();
    chk("t1_change", int'(change), 1);
    chk("t1_pending_clr", int'(pending), 0);
    repeat (22) tick();
    chk("t1_timeout", int'(change), 0);

    // Ack while idle is ignored
    ack = 1'b1; tick(); ack = 1'b0;
    chk("idle_ack", int'(change), 0);

    // Ack on 3rd report cycle
    set_ch(2, 3);
    push(2, 5, 3, 3);
    tick(); tick();
    chk("t2_change", int'(change), 1);
    tick(); tick();
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t2_ack_fall", int'(change), 0);

    // Simultaneous ch3 and ch1: ch1 first, idle gap, then ch3
    tick();
    set_ch(3, 7);
    set_ch(1, 2);
    push(1, 0, 2, 1);
    push(3, 0, 7, 1);
    tick();
    chk("t3_pending", int'(pending), 4'b1010);
    tick();
    chk("t3_ch1", int'(change_ch), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    chk("t3_gap", int'(change), 0);
    tick();
    chk("t3_ch3_up", int'(change), 1);
    ack = 1'b1; tick(); ack = 1'b0;

    // Coalescing on ch0 during a ch2 report
    tick();
    set_ch(2, 4);
    push(2, 3, 4, HOLD);
    push(0, 0, 6, 1);
    tick(); tick();
    set_ch(0, 1);
    tick();
    chk("t4_no_overrun", int'(overrun), 0);
    set_ch(0, 6);
    tick();
    chk("t4_overrun", int'(overrun), 1);
    chk("t4_pending0", int'(pending[0]), 1);
    tick();
    chk("t4_overrun_pulse", int'(overrun), 0);
    wait_change(1'b0, 30, "t4_ch2_end");
    wait_change(1'b1, 5, "t4_ch0_start");
    ack = 1'b1; tick(); ack = 1'b0;

    // Set beats clear on ch1
    tick();
    set_ch(1, 3);
    push(1, 2, 3, 1);
    push(1, 3, 4, 1);
    tick();
    set_ch(1, 4);
    tick();
    chk("t5_change", int'(change), 1);
    chk("t5_pending1", int'(pending[1]), 1);
    ack = 1'b1; tick(); ack = 1'b0;
    wait_change(1'b1, 5, "t5_second");
    ack = 1'b1; tick(); ack = 1'b0;

    // Reset mid-report drops it immediately
    tick();
    set_ch(3, 1);
    push(3, 7, 1, 1);
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("t6_change", int'(change), 0);
    chk("t6_ch", int'(change_ch), 0);
    chk("t6_prev", int'(change_prev), 0);
    chk("t6_value", int'(change_value), 0);
    chk("t6_pending", int'(pending), 0);
    chk("t6_overrun", int'(overrun), 0);
    sig_in = '0;
    tick();
    rst_n = 1'b1;
    repeat (5) tick();
    chk("t6_post_pending", int'(pending), 0);
    chk("t6_post_change", int'(change), 0);
`endif

    repeat (3) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_change_detector.md
# multi_change_detector

Multi-channel change detector for the LCD 16x2 front end: watches CHANNELS independent WIDTH-bit status fields and reports each value change as a held `change` strobe with channel index, old value and new value. It waits for an `ack` from the display controller, or a timeout, before reporting the next change. Changes on several channels are queued per channel and served lowest-index first. Repeated changes on a channel that is still waiting are coalesced, and the coalescing is flagged.

## Interface
- CHANNELS, 4: number of monitored fields (≥1)
- WIDTH, 3: bits per field (≥1)
- HOLD_CYCLES, 20: maximum cycles `change` stays high without `ack` (≥1)
- STABLE_CYCLES, 4: debounce length, used only with CHANGE_DEBOUNCE_EN (≥1)
- CW = max(1, $clog2(CHANNELS)): channel index width (derived)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low; asserting it clears all state immediately
- sig_in  in  CHANNELS*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
- ack  in  1  consumer accepts current report; ignored unless `change`=1
- change  out  1  report valid
- change_ch  out  CW  channel being reported
- change_prev  out  WIDTH  value before the change
- change_value  out  WIDTH  value after the change (latest if coalesced)
- pending  out  CHANNELS  per-channel queued-change flags
- overrun  out  1  one-cycle pulse: an already-pending channel changed again

## Operation
- Per channel k, the block keeps three registers: `last_k` (accepted value, reset 0), `prev_k` (value before the first unreported change), and `pend_k`.
- Detection: at an edge where sig_in[k] ≠ last_k:
  - last_k ← sig_in[k];
  - if pend_k=0: prev_k ← last_k and pend_k ← 1;
  - if pend_k=1: prev_k is unchanged and overrun pulses for one cycle.
- FSM states are IDLE and REPORT.
- IDLE:
  - If any pend bit is set, pick the lowest index j.
  - Latch change_ch←j, change_prev←prev_j, change_value←last_j.
  - Clear pend_j and go to REPORT.
  - Otherwise stay in IDLE.
- REPORT:
  - `change`=1 and the output fields are frozen.
  - A hold counter (width $clog2(HOLD_CYCLES+1)) counts cycles spent in REPORT.
  - Go to IDLE when `ack`=1, or when the counter reaches HOLD_CYCLES−1 (timeout).
  - The counter clears on leaving REPORT.
- Set wins over clear: if channel j changes on the same edge its pend_j is cleared by the latch, pend_j stays 1 and prev_j ← the value just reported.
- Changes arriving during REPORT, on any channel including the one being reported, only update pend/prev/last. They never alter the frozen outputs.
- An `ack` arriving while in IDLE is ignored.
- Reset: change=0, change_ch=0, change_prev=0, change_value=0, pending=0, overrun=0, all last/prev=0, FSM=IDLE, counter=0. If reset is asserted mid-REPORT, the report is dropped with no completion.

## Timing
- pending[k] rises one edge after sig_in[k] differs at an edge (latency 1).
- `change` rises one edge later if the FSM was IDLE, so sig_in to change is 2 edges.
- `ack` sampled high at an edge: `change` falls at that same edge, so the minimum report length is 1 cycle.
- No ack: `change` is high for exactly HOLD_CYCLES cycles.
- Between consecutive reports there is always at least one cycle with change=0 (IDLE).
- Channel values equal to their reset value (0) after reset produce no report.

## Configuration
- CHANGE_DEBOUNCE_EN defined:
  - Each channel has a stability counter; a value ≠ last_k is accepted only after sig_in[k] has held that same value for STABLE_CYCLES consecutive edges.
  - Any further change in the input restarts the count.
  - Latency from sig_in to pending becomes STABLE_CYCLES+1 edges.
  - Glitches shorter than STABLE_CYCLES produce nothing.
- CHANGE_DEBOUNCE_EN undefined: no stability counters; timing exactly as in Timing.

## Test plan
- Single change, no ack: CHANNELS=4, WIDTH=3, HOLD_CYCLES=20; ch2 goes 0→5 → pending=4'b0100 after 1 edge, then change=1, ch=2, prev=0, value=5 for exactly 20 cycles; pending=0 during the report.
- Ack early: same stimulus, ack on the 3rd cycle of REPORT → change falls at that edge, FSM returns to IDLE.
- Simultaneous changes: ch3 and ch1 change on the same edge → report ch1 first, ack, one idle cycle, then ch3.
- Coalescing: ch0 goes 0→1 then 1→6 while ch2 is being reported → one overrun pulse; the later ch0 report shows prev=0, value=6.
- Set beats clear: ch1 goes 3→4 on the exact edge the ch1 report latches → report shows prev=x, value=3, pending[1] stays 1, and the next report shows prev=3, value=4.
- Reset and debounce: assert reset mid-REPORT → all outputs 0 immediately. With CHANGE_DEBOUNCE_EN and STABLE_CYCLES=4, a 3-cycle glitch on ch0 → no pending; a 4-cycle hold → pending[0] rises after 5 edges.
